// File: rtl/time_counter.sv
// Time-of-day counter: turns each rising edge of the divided tick into a
// seconds strobe and keeps hh:mm:ss as packed BCD, with a manual adjust mode.
module time_counter #(
  parameter int unsigned HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run_en,
  input  logic       adj_en,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       clr_sec,
  output logic [3:0] sec_o,
  output logic [3:0] sec_t,
  output logic [3:0] min_o,
  output logic [3:0] min_t,
  output logic [3:0] hr_o,
  output logic [3:0] hr_t,
  output logic       sec_pulse,
  output logic       day_wrap
);

  localparam int unsigned HrLast = HOUR_MOD - 1;
  localparam logic [7:0] HrLastBcd = {4'(HrLast / 10), 4'(HrLast % 10)};

  // {tens, ones} BCD pair counting 00..59
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      else                return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // {tens, ones} BCD pair counting 00..HOUR_MOD-1
  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    if (v == HrLastBcd)  return 8'h00;
    if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [7:0] r_sec, r_min, r_hr;
  logic       r_tick_d, r_primed, r_sec_pulse, r_day_wrap;

  logic [7:0] w_sec_d, w_min_d, w_hr_d;
  logic       w_edge, w_count, w_wrap_d;

  // primed masks the first cycle after reset so a tick already high is not an edge
  assign w_edge  = tick & ~r_tick_d & r_primed;
  assign w_count = w_edge & run_en & ~adj_en;

  // Next-state time: counting with full carry chain, or independent adjust actions
  always_comb begin
    w_sec_d  = r_sec;
    w_min_d  = r_min;
    w_hr_d   = r_hr;
    w_wrap_d = 1'b0;
    if (w_count) begin
      w_sec_d = inc_mod60(r_sec);
      if (r_sec == 8'h59) begin
        w_min_d = inc_mod60(r_min);
        if (r_min == 8'h59) begin
          w_hr_d   = inc_hr(r_hr);
          w_wrap_d = (r_hr == HrLastBcd);
        end
      end
    end else if (adj_en) begin
      if (clr_sec)  w_sec_d = 8'h00;
      if (inc_min)  w_min_d = inc_mod60(r_min);
      if (inc_hour) w_hr_d  = inc_hr(r_hr);
    end
  end

  // State and registered strobes, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec       <= 8'h00;
      r_min       <= 8'h00;
      r_hr        <= 8'h00;
      r_tick_d    <= 1'b0;
      r_primed    <= 1'b0;
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
    end else begin
      r_sec       <= w_sec_d;
      r_min       <= w_min_d;
      r_hr        <= w_hr_d;
      r_tick_d    <= tick;
      r_primed    <= 1'b1;
      r_sec_pulse <= w_count;
      r_day_wrap  <= w_wrap_d;
    end
  end

  assign sec_o     = r_sec[3:0];
  assign sec_t     = r_sec[7:4];
  assign min_o     = r_min[3:0];
  assign min_t     = r_min[7:4];
  assign hr_o      = r_hr[3:0];
  assign hr_t      = r_hr[7:4];
  assign sec_pulse = r_sec_pulse;
  assign day_wrap  = r_day_wrap;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: two instances (24 h and 12 h) driven in parallel,
// checked against a seconds-of-day model plus fixed vector tables.
module tb_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick, run_en, adj_en, inc_min, inc_hour, clr_sec;

  logic [3:0] a_sec_o, a_sec_t, a_min_o, a_min_t, a_hr_o, a_hr_t;
  logic [3:0] b_sec_o, b_sec_t, b_min_o, b_min_t, b_hr_o, b_hr_t;
  logic       a_pulse, a_wrap, b_pulse, b_wrap;
  logic [25:0] a_vec, b_vec;

  always #5 clk = ~clk;

  time_counter #(.HOUR_MOD(24)) dut24 (
    .clk(clk), .rst(rst), .tick(tick), .run_en(run_en), .adj_en(adj_en),
    .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
    .sec_o(a_sec_o), .sec_t(a_sec_t), .min_o(a_min_o), .min_t(a_min_t),
    .hr_o(a_hr_o), .hr_t(a_hr_t), .sec_pulse(a_pulse), .day_wrap(a_wrap)
  );

  time_counter #(.HOUR_MOD(12)) dut12 (
    .clk(clk), .rst(rst), .tick(tick), .run_en(run_en), .adj_en(adj_en),
    .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
    .sec_o(b_sec_o), .sec_t(b_sec_t), .min_o(b_min_o), .min_t(b_min_t),
    .hr_o(b_hr_o), .hr_t(b_hr_t), .sec_pulse(b_pulse), .day_wrap(b_wrap)
  );

  assign a_vec = {a_hr_t, a_hr_o, a_min_t, a_min_o, a_sec_t, a_sec_o, a_pulse, a_wrap};
  assign b_vec = {b_hr_t, b_hr_o, b_min_t, b_min_o, b_sec_t, b_sec_o, b_pulse, b_wrap};

  int n_err = 0;
  int n_chk = 0;
  int pulse_cnt = 0;
  bit wrap12_seen = 0;

  // Reference model: time kept as seconds since midnight
  int unsigned m_t[2];
  bit          m_pulse[2], m_wrap[2];
  bit          m_prev_tick, m_primed;
  int unsigned mods[2] = '{24, 12};

  function automatic logic [25:0] pack_exp(input int unsigned t, input bit p, input bit w);
    int unsigned h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), p, w};
  endfunction

  function automatic int unsigned hms(input int unsigned h, input int unsigned m,
                                      input int unsigned s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got hhmmss/p/w=%h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_tick = 0;
    m_primed    = 0;
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_pulse[i] = 0; m_wrap[i] = 0;
    end
  endtask

  task automatic model_cycle();
    bit e;
    int unsigned h, m, s;
    e = tick && !m_prev_tick && m_primed;
    m_prev_tick = tick;
    m_primed    = 1;
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      m_wrap[i]  = 0;
      if (e && run_en && !adj_en) begin
        m_pulse[i] = 1;
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == mods[i] * 3600) begin
          m_t[i] = 0;
          m_wrap[i] = 1;
        end
      end else if (adj_en) begin
        h = m_t[i] / 3600;
        m = (m_t[i] / 60) % 60;
        s = m_t[i] % 60;
        if (clr_sec)  s = 0;
        if (inc_min)  m = (m + 1) % 60;
        if (inc_hour) h = (h + 1) % mods[i];
        m_t[i] = hms(h, m, s);
      end
    end
  endtask

  // One clock: model consumes the same inputs the DUT samples, then compare
  task automatic step();
    @(posedge clk);
    model_cycle();
    #1;
    check("model24", a_vec, pack_exp(m_t[0], m_pulse[0], m_wrap[0]));
    check("model12", b_vec, pack_exp(m_t[1], m_pulse[1], m_wrap[1]));
    if (a_pulse) pulse_cnt++;
    if (b_wrap) wrap12_seen = 1;
  endtask

  task automatic set_in(input bit tk, input bit r, input bit a, input bit im, input bit ih,
                        input bit cs);
    tick = tk; run_en = r; adj_en = a; inc_min = im; inc_hour = ih; clr_sec = cs;
  endtask

  task automatic tick_edges(input int n);
    repeat (n) begin
      tick = 1; step();
      tick = 0; step();
    end
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      inc_min = 1; step();
      inc_min = 0; step();
    end
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin
      inc_hour = 1; step();
      inc_hour = 0; step();
    end
  endtask

  // Asynchronous assertion checked before any clock edge, then release
  task automatic apply_reset();
    rst = 0;
    #1;
    model_reset();
    check("reset_async24", a_vec, 26'd0);
    check("reset_async12", b_vec, 26'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  typedef struct {
    bit tk, run, adj, im, ih, cs;
    bit pulse;
    int unsigned h, m, s;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};  // tick high at release: not counted
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 1};  // genuine rise
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1};  // held high
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};  // run_en=0 drops the edge
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};  // adj_en wins over edge
    tbl[8]  = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 2};
    tbl[10] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};  // clr_sec + inc_hour together
    tbl[11] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

    set_in(1, 1, 0, 0, 0, 0);
    #2;
    apply_reset();

    // Vector table from reset with tick already high
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].tk, tbl[i].run, tbl[i].adj, tbl[i].im, tbl[i].ih, tbl[i].cs);
      step();
      check($sformatf("vec%0d", i), a_vec,
            pack_exp(hms(tbl[i].h, tbl[i].m, tbl[i].s), tbl[i].pulse, 1'b0));
    end

    // 60 seconds from reset
    set_in(0, 1, 0, 0, 0, 0);
    apply_reset();
    step();
    pulse_cnt = 0;
    tick_edges(60);
    check_int("pulses_60", pulse_cnt, 60);
    check("time_00_01_00", a_vec, pack_exp(hms(0, 1, 0), 0, 0));

    // Day wrap from 23:59:58
    set_in(0, 1, 1, 0, 0, 0);
    apply_reset();
    step();
    pulse_hour(23);
    pulse_min(59);
    adj_en = 0;
    tick_edges(58);
    check("pre_235958", a_vec, pack_exp(hms(23, 59, 58), 0, 0));
    tick = 1; step();
    check("at_235959", a_vec, pack_exp(hms(23, 59, 59), 1, 0));
    tick = 0; step();
    tick = 1; step();
    check("wrap24", a_vec, pack_exp(0, 1, 1));
    check("wrap12", b_vec, pack_exp(0, 1, 1));
    tick = 0; step();
    check("wrap24_one_cycle", a_vec, pack_exp(0, 0, 0));

    // Hour adjust in 12 h mode never raises day_wrap
    set_in(0, 1, 0, 0, 0, 0);
    apply_reset();
    step();
    tick_edges(2);
    adj_en = 1;
    pulse_min(3);
    wrap12_seen = 0;
    pulse_hour(11);
    check("hr12_after11", b_vec, pack_exp(hms(11, 3, 2), 0, 0));
    pulse_hour(1);
    check("hr12_after12", b_vec, pack_exp(hms(0, 3, 2), 0, 0));
    check("hr24_after12", a_vec, pack_exp(hms(12, 3, 2), 0, 0));
    check_int("no_wrap_adjust", int'(wrap12_seen), 0);

    // Edges under adjust dropped; inc_min + clr_sec in one cycle
    set_in(0, 1, 1, 0, 0, 0);
    apply_reset();
    step();
    pulse_min(59);
    adj_en = 0;
    tick_edges(37);
    adj_en = 1;
    pulse_cnt = 0;
    tick_edges(5);
    check_int("no_pulse_in_adjust", pulse_cnt, 0);
    check("hold_005937", a_vec, pack_exp(hms(0, 59, 37), 0, 0));
    inc_min = 1; clr_sec = 1;
    step();
    inc_min = 0; clr_sec = 0;
    check("min_clr_24", a_vec, pack_exp(0, 0, 0));
    check("min_clr_12", b_vec, pack_exp(0, 0, 0));

    // Asynchronous reset at 12:34:56, then resume
    set_in(0, 1, 1, 0, 0, 0);
    apply_reset();
    step();
    pulse_hour(12);
    pulse_min(34);
    adj_en = 0;
    tick_edges(56);
    check("pre_123456", a_vec, pack_exp(hms(12, 34, 56), 0, 0));
    #3;
    apply_reset();
    step();
    tick_edges(3);
    check("resume_000003", a_vec, pack_exp(3, 0, 0));

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        run_en = ($urandom_range(0, 3) != 0);
        adj_en = ($urandom_range(0, 4) == 0);
      end
      tick     = 1'($urandom_range(0, 1));
      inc_min  = ($urandom_range(0, 7) == 0);
      inc_hour = ($urandom_range(0, 7) == 0);
      clr_sec  = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
